// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and the clocks-per-bit helper.
// Used by both the byte transmitter and the byte receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte queue with explicit occupancy count; head entry is visible on pop_data.
// Pushes while full and pops while empty are ignored.
module byte_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_byte_tx.sv
// Buffered UART transmitter: valid/ready byte input, FIFO, registered serial TxD (8N1).
// Define UART_TX_PARITY_EN to compile in an even-parity bit (8E1 frames).
module uart_byte_tx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [7:0]                      in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            TxD,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  import uart_pkg::*;

  localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD);
  localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] DIV_LAST = BW'(DIV - 1);

  tx_state_t   state;
  tx_state_t   state_next;
  logic [BW-1:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        bit_done;
  logic        txd_d;
  logic        txd_q;
  logic        busy_q;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [7:0]  head_data;
`ifdef UART_TX_PARITY_EN
  logic        parity_bit;
`endif

  assign push     = in_valid && !full;
  assign in_ready = !full;
  assign bit_done = (baud_cnt == DIV_LAST);
  assign TxD      = txd_q;
  assign busy     = busy_q;

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (head_data),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!empty) state_next = START;
      START: if (bit_done) state_next = DATA;
      DATA: begin
        if (bit_done && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) state_next = STOP;
`endif
      STOP:  if (bit_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    txd_d = 1'b1;
    pop   = 1'b0;
    case (state)
      IDLE:  pop   = !empty;
      START: txd_d = 1'b0;
      DATA:  txd_d = shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: txd_d = parity_bit;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  // Counters restart on every pop so bit edges line up with the frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (pop) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (state != IDLE) begin
      if (bit_done) begin
        baud_cnt <= '0;
        if (state == DATA) bit_cnt <= bit_cnt + 3'd1;
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shift <= head_data;
    end else if (state == DATA && bit_done) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (pop) parity_bit <= ^head_data;
  end
`endif

  // TxD lags the state by one clock, keeping the line fully registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      txd_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      txd_q  <= txd_d;
      busy_q <= (state_next != IDLE) || !empty || push;
    end
  end

endmodule
